// File: rtl/div_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the RV32M divide sequencer.
package div_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  localparam logic [6:0] OPCODE_OP    = 7'b0110011;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] INT_MIN   = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FIX    = 2'd2,
    DONE_S = 2'd3
  } state_t;

  // Operation context captured when a divide is accepted
  typedef struct packed {
    logic [2:0] func3;
    logic       neg1;
    logic       neg2;
  } op_t;

  function automatic logic is_signed_op(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

  function automatic logic is_div_class(input logic [6:0] opcode, input logic [6:0] func7,
                                        input logic [2:0] f3);
    return (opcode == OPCODE_OP) && (func7 == FUNC7_MULDIV) &&
           ((f3 == F3_DIV) || (f3 == F3_DIVU) || is_rem_op(f3));
  endfunction

  // Magnitude for signed ops; INT_MIN maps to itself as an unsigned value
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
    return (sgn && v[XLEN-1]) ? XLEN'(-v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left and trial-subtract the divisor.
module div_step
  import div_sequencer_pkg::*;
(
  input  logic [XLEN-1:0] rem,
  input  logic [XLEN-1:0] quo,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;
  logic          ok;

  // Partial remainder can reach 33 bits after the shift when the divisor is large
  always_comb begin
    shifted  = {rem, quo[XLEN-1]};
    diff     = shifted - {1'b0, divisor};
    ok       = (shifted >= {1'b0, divisor});
    rem_next = ok ? XLEN'(diff) : XLEN'(shifted);
    quo_next = {quo[XLEN-2:0], ok};
  end

endmodule

// File: rtl/div_sequencer.sv
// EX-stage sequencer for DIV/DIVU/REM/REMU: fast paths, 32-step restoring loop, sign fix.
module div_sequencer
  import div_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_t          state_q, state_n;
  op_t             op_q;
  logic [XLEN-1:0] rem_q, quo_q, dvs_q;
  logic [XLEN-1:0] rem_nx, quo_nx, rem_fix, quo_fix, fast_res;
  logic [CNT_W-1:0] cnt_q;
  logic            sgn_in, div0, ovf, fast, accept, last_step;

  div_step u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  // Acceptance and fast-path decode on the live inputs
  always_comb begin
    sgn_in    = is_signed_op(func3);
    div0      = (operand2 == '0);
    ovf       = sgn_in && (operand1 == INT_MIN) && (operand2 == DIV0_QUOT);
    fast      = div0 || ovf;
    accept    = (state_q == IDLE) && start && !flush;
    last_step = (cnt_q == CNT_W'(XLEN - 1));
    fast_res  = '0;
    if (div0)
      fast_res = is_rem_op(func3) ? operand1 : DIV0_QUOT;
    else
      fast_res = is_rem_op(func3) ? '0 : INT_MIN;
    quo_fix = (op_q.neg1 ^ op_q.neg2) ? XLEN'(-quo_q) : quo_q;
    rem_fix = op_q.neg1 ? XLEN'(-rem_q) : rem_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_n = fast ? DONE_S : CALC;
      CALC:    if (flush) state_n = IDLE;
               else if (last_step) state_n = FIX;
      FIX:     state_n = flush ? IDLE : DONE_S;
      DONE_S:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Stall drops in DONE_S so the pipeline captures the result and advances
  always_comb begin
    stall = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    stall = !rst && (accept || (state_q == CALC) || (state_q == FIX));
    busy  = (state_q != IDLE);
    done  = (state_q == DONE_S) && !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      result <= '0;
    end else begin
      cnt_q <= ((state_q == CALC) && !flush && !last_step) ? cnt_q + CNT_W'(1) : '0;
      if (accept) begin
        op_q  <= '{func3: func3, neg1: sgn_in & operand1[XLEN-1], neg2: sgn_in & operand2[XLEN-1]};
        dvs_q <= mag(operand2, sgn_in);
        quo_q <= mag(operand1, sgn_in);
        rem_q <= '0;
        if (fast) result <= fast_res;
      end else if ((state_q == CALC) && !flush) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
      end
      if ((state_q == FIX) && !flush)
        result <= is_rem_op(op_q.func3) ? rem_fix : quo_fix;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, stall window, fast paths, flush and reset.
module tb_div_sequencer;
  import div_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  func3 = F3_DIVU;
  logic [31:0] operand1 = '0;
  logic [31:0] operand2 = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_err = 0;

  div_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .func3    (func3),
    .operand1 (operand1),
    .operand2 (operand2),
    .flush    (flush),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op at a negedge (cycle t), then measure DONE latency and stalled cycles
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    int lat;
    int stall_cnt;
    @(negedge clk);
    func3 = f3; operand1 = a; operand2 = b; start = 1'b1;
    #1;
    stall_cnt = stall ? 1 : 0;
    @(posedge clk);
    #1;
    start = 1'b0; operand1 = 32'hDEAD_BEEF; operand2 = 32'd1; func3 = F3_DIVU;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, result, exp);
    check({tag, "_stall"}, 32'(stall_cnt), 32'(exp_lat));
    @(negedge clk);
    check({tag, "_idle"}, {30'd0, busy, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
  endtask

  initial begin
    logic [31:0] prev;
    logic        saw_done;

    // Reset values, and stall held low during reset even with start high
    start = 1'b1;
    #12;
    check("rst_out", {29'd0, stall, busy, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;

    run_op(F3_DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7");
    run_op(F3_REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7");
    run_op(F3_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(F3_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run_op(F3_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, "div_7_m2");
    run_op(F3_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 34, "div_m100_m7");
    run_op(F3_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 34, "rem_m100_m7");
    run_op(F3_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div_5_0");
    run_op(F3_REMU, 32'd5, 32'd0, 32'd5, 1, "remu_5_0");
    run_op(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");
    run_op(F3_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, "divu_big");
    run_op(F3_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, "remu_big");
    run_op(F3_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 34, "divu_max_1");

    // Flush wins over start in IDLE
    @(negedge clk);
    func3 = F3_DIV; operand1 = 32'd50; operand2 = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_pri_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_pri_busy", {31'd0, busy}, 32'd0);

    // Flush during CALC at t+10
    prev = result;
    saw_done = 1'b0;
    @(negedge clk);
    func3 = F3_DIVU; operand1 = 32'd1000; operand2 = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    check("flush_calc_busy", {31'd0, busy}, 32'd1);
    flush = 1'b1;
    #1;
    check("flush_calc_done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    if (done) saw_done = 1'b1;
    check("flush_idle", {30'd0, busy, stall}, 32'd0);
    check("flush_result", result, prev);
    check("flush_no_done", {31'd0, saw_done}, 32'd0);
    run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 34, "divu_9_3");

    // Asynchronous reset mid-CALC
    @(negedge clk);
    func3 = F3_DIVU; operand1 = 32'd100; operand2 = 32'd7; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k <= 5; k++) @(negedge clk);
    check("rst_mid_busy_pre", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out", {29'd0, stall, busy, done}, 32'd0);
    check("rst_mid_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_post_idle", {30'd0, busy, stall}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
